// File: rtl/wb_bridge_pkg.sv
// Shared definitions for the valid/ready to Wishbone classic bridge:
// response codes, FSM state encoding and a constant-foldable clog2.
package wb_bridge_pkg;

    // Response codes returned to the core. Zero is never issued, so a
    // zero code can only be seen out of reset.
    localparam int RESP_OKAY    = 1;
    localparam int RESP_ERR     = 2;
    localparam int RESP_TIMEOUT = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Ceiling log2, usable in localparam expressions. clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/wb_bridge_timeout_counter.sv
// Bus watchdog: counts wait cycles of the current Wishbone cycle and flags
// expiry on the timeout_cycles-th wait cycle. timeout_cycles = 0 disables it.
module wb_timeout_counter
    import wb_bridge_pkg::*;
#(
    parameter int timeout_cycles = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W_RAW = clog2(timeout_cycles + 1);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    // Count value seen during the last permitted wait cycle.
    localparam int LIMIT     = (timeout_cycles > 0) ? (timeout_cycles - 1) : 0;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             at_limit;

    assign at_limit = (count_q == CNT_W'(LIMIT));
    // A zero timeout makes the first term constant false, so expiry never fires.
    assign expired  = (timeout_cycles != 0) && enable && at_limit;

    // Next count: clear wins, otherwise advance on each unterminated wait cycle.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_bridge.sv
// Bridge from the core's split valid/ready read/write channels to a single
// Wishbone classic master. One transaction in flight, fair read/write
// arbitration on ties, err propagation and a bus-timeout watchdog.
module wb_bridge
    import wb_bridge_pkg::*;
#(
    parameter int addr_width     = 32,
    parameter int data_width     = 32,
    parameter int strobe_width   = data_width / 8,
    parameter int resp_width     = 2,
    parameter int timeout_cycles = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    // Wishbone master
    output logic [addr_width-1:0]   wb_adr,
    output logic [data_width-1:0]   wb_datwr,
    input  logic [data_width-1:0]   wb_datrd,
    output logic                    wb_we,
    output logic [strobe_width-1:0] wb_sel,
    output logic                    wb_cyc,
    output logic                    wb_stb,
    input  logic                    wb_ack,
    input  logic                    wb_err,
    // Read address channel
    output logic                    bus_r_addr_ready,
    input  logic                    bus_r_addr_valid,
    input  logic [addr_width-1:0]   bus_r_addr,
    // Read data channel
    input  logic                    bus_r_data_ready,
    output logic                    bus_r_data_valid,
    output logic [data_width-1:0]   bus_r_data,
    output logic [resp_width-1:0]   bus_r_resp,
    // Write address+data channel
    output logic                    bus_w_data_addr_ready,
    input  logic                    bus_w_data_addr_valid,
    input  logic [data_width-1:0]   bus_w_data,
    input  logic [addr_width-1:0]   bus_w_addr,
    input  logic [strobe_width-1:0] bus_w_strobe,
    // Write response channel
    input  logic                    bus_w_resp_ready,
    output logic                    bus_w_resp_valid,
    output logic [resp_width-1:0]   bus_w_resp
);

    localparam logic [resp_width-1:0] CODE_OKAY    = resp_width'(RESP_OKAY);
    localparam logic [resp_width-1:0] CODE_ERR     = resp_width'(RESP_ERR);
    localparam logic [resp_width-1:0] CODE_TIMEOUT = resp_width'(RESP_TIMEOUT);

    state_t state_q, state_d;

    logic                    last_was_write_q, last_was_write_d;
    // Set by the first grant; before it a tie goes to the read channel.
    logic                    granted_any_q, granted_any_d;

    logic [addr_width-1:0]   wb_adr_q, wb_adr_d;
    logic [data_width-1:0]   wb_datwr_q, wb_datwr_d;
    logic [strobe_width-1:0] wb_sel_q, wb_sel_d;
    logic                    wb_we_q, wb_we_d;
    logic                    wb_cyc_q, wb_cyc_d;
    logic [data_width-1:0]   r_data_q, r_data_d;
    logic [resp_width-1:0]   r_resp_q, r_resp_d;
    logic                    r_valid_q, r_valid_d;
    logic [resp_width-1:0]   w_resp_q, w_resp_d;
    logic                    w_valid_q, w_valid_d;

    logic                    in_idle;
    logic                    busy;
    logic                    tie;
    logic                    write_wins_tie;
    logic                    accept_r;
    logic                    accept_w;
    logic                    term_err;
    logic                    term_ack;
    logic                    term_to;
    logic                    terminate;
    logic [resp_width-1:0]   term_code;
    logic                    resp_done;
    logic                    wd_expired;

    assign in_idle        = (state_q == ST_IDLE);
    assign busy           = (state_q == ST_READ) || (state_q == ST_WRITE);
    assign tie            = bus_r_addr_valid && bus_w_data_addr_valid;
    assign write_wins_tie = granted_any_q && !last_was_write_q;

    // Readies decode from state and the arbitration flag; on a tie only
    // the winner sees ready so the loser simply stays pending.
    assign bus_r_addr_ready      = in_idle && !(tie && write_wins_tie);
    assign bus_w_data_addr_ready = in_idle && !(tie && !write_wins_tie);
    assign accept_r              = bus_r_addr_valid && bus_r_addr_ready;
    assign accept_w              = bus_w_data_addr_valid && bus_w_data_addr_ready;

    // err outranks ack, and either outranks the watchdog.
    assign term_err  = busy && wb_err;
    assign term_ack  = busy && wb_ack && !wb_err;
    assign term_to   = busy && !wb_ack && !wb_err && wd_expired;
    assign terminate = term_err || term_ack || term_to;
    assign term_code = term_err ? CODE_ERR : (term_ack ? CODE_OKAY : CODE_TIMEOUT);

    assign resp_done = (r_valid_q && bus_r_data_ready) || (w_valid_q && bus_w_resp_ready);

    wb_timeout_counter #(
        .timeout_cycles (timeout_cycles)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (accept_r || accept_w),
        .enable  (busy && !wb_ack && !wb_err),
        .expired (wd_expired)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_r) begin
                    state_d = ST_READ;
                end else if (accept_w) begin
                    state_d = ST_WRITE;
                end
            end
            ST_READ, ST_WRITE: begin
                if (terminate) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: next values for the registered bus and response outputs.
    always_comb begin
        last_was_write_d = last_was_write_q;
        granted_any_d    = granted_any_q;
        wb_adr_d         = wb_adr_q;
        wb_datwr_d       = wb_datwr_q;
        wb_sel_d         = wb_sel_q;
        wb_we_d          = wb_we_q;
        wb_cyc_d         = wb_cyc_q;
        r_data_d         = r_data_q;
        r_resp_d         = r_resp_q;
        r_valid_d        = r_valid_q;
        w_resp_d         = w_resp_q;
        w_valid_d        = w_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_r) begin
                    wb_adr_d         = bus_r_addr;
                    wb_sel_d         = {strobe_width{1'b1}};
                    wb_we_d          = 1'b0;
                    wb_cyc_d         = 1'b1;
                    last_was_write_d = 1'b0;
                    granted_any_d    = 1'b1;
                end else if (accept_w) begin
                    wb_adr_d         = bus_w_addr;
                    wb_datwr_d       = bus_w_data;
                    wb_sel_d         = bus_w_strobe;
                    wb_we_d          = 1'b1;
                    wb_cyc_d         = 1'b1;
                    last_was_write_d = 1'b1;
                    granted_any_d    = 1'b1;
                end
            end
            ST_READ, ST_WRITE: begin
                if (terminate) begin
                    wb_cyc_d = 1'b0;
                    if (state_q == ST_READ) begin
                        r_data_d  = term_ack ? wb_datrd : '0;
                        r_resp_d  = term_code;
                        r_valid_d = 1'b1;
                    end else begin
                        w_resp_d  = term_code;
                        w_valid_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                if (r_valid_q && bus_r_data_ready) begin
                    r_valid_d = 1'b0;
                end
                if (w_valid_q && bus_w_resp_ready) begin
                    w_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Output and arbitration registers; reset aborts any cycle in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_was_write_q <= 1'b0;
            granted_any_q    <= 1'b0;
            wb_adr_q         <= '0;
            wb_datwr_q       <= '0;
            wb_sel_q         <= '0;
            wb_we_q          <= 1'b0;
            wb_cyc_q         <= 1'b0;
            r_data_q         <= '0;
            r_resp_q         <= '0;
            r_valid_q        <= 1'b0;
            w_resp_q         <= '0;
            w_valid_q        <= 1'b0;
        end else begin
            last_was_write_q <= last_was_write_d;
            granted_any_q    <= granted_any_d;
            wb_adr_q         <= wb_adr_d;
            wb_datwr_q       <= wb_datwr_d;
            wb_sel_q         <= wb_sel_d;
            wb_we_q          <= wb_we_d;
            wb_cyc_q         <= wb_cyc_d;
            r_data_q         <= r_data_d;
            r_resp_q         <= r_resp_d;
            r_valid_q        <= r_valid_d;
            w_resp_q         <= w_resp_d;
            w_valid_q        <= w_valid_d;
        end
    end

    assign wb_adr           = wb_adr_q;
    assign wb_datwr         = wb_datwr_q;
    assign wb_sel           = wb_sel_q;
    assign wb_we            = wb_we_q;
    assign wb_cyc           = wb_cyc_q;
    assign wb_stb           = wb_cyc_q;
    assign bus_r_data       = r_data_q;
    assign bus_r_resp       = r_resp_q;
    assign bus_r_data_valid = r_valid_q;
    assign bus_w_resp       = w_resp_q;
    assign bus_w_resp_valid = w_valid_q;

endmodule

// File: tb/tb_wb_bridge.sv
// Scoreboard bench for wb_bridge: expected responses are queued at request
// acceptance and checked when the bridge presents them.
module tb_wb_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int RW = 2;
    localparam int TO = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] wb_adr;
    logic [DW-1:0] wb_datwr;
    logic [DW-1:0] wb_datrd;
    logic          wb_we;
    logic [SW-1:0] wb_sel;
    logic          wb_cyc;
    logic          wb_stb;
    logic          wb_ack;
    logic          wb_err;
    logic          bus_r_addr_ready;
    logic          bus_r_addr_valid;
    logic [AW-1:0] bus_r_addr;
    logic          bus_r_data_ready;
    logic          bus_r_data_valid;
    logic [DW-1:0] bus_r_data;
    logic [RW-1:0] bus_r_resp;
    logic          bus_w_data_addr_ready;
    logic          bus_w_data_addr_valid;
    logic [DW-1:0] bus_w_data;
    logic [AW-1:0] bus_w_addr;
    logic [SW-1:0] bus_w_strobe;
    logic          bus_w_resp_ready;
    logic          bus_w_resp_valid;
    logic [RW-1:0] bus_w_resp;

    int total = 0;
    int bad = 0;
    int cycle_no = 0;

    typedef struct {
        logic          is_write;
        logic [RW-1:0] resp;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Slave model: 0 = silent, 1 = ack, 2 = err+ack, on cyc cycle slave_cycle.
    int            slave_mode = 0;
    int            slave_cycle = 1;
    logic [DW-1:0] slave_rdata = '0;
    logic          slave_ack = 1'b0;
    logic          slave_err = 1'b0;
    logic          manual_ack = 1'b0;
    int            wait_cnt = 0;
    logic [AW-1:0] seen_adr = '0;
    logic [DW-1:0] seen_datwr = '0;
    logic [SW-1:0] seen_sel = '0;
    logic          seen_we = 1'b0;

    assign wb_ack   = slave_ack | manual_ack;
    assign wb_err   = slave_err;
    assign wb_datrd = slave_rdata;

    wb_bridge #(
        .addr_width     (AW),
        .data_width     (DW),
        .strobe_width   (SW),
        .resp_width     (RW),
        .timeout_cycles (TO)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .wb_adr                (wb_adr),
        .wb_datwr              (wb_datwr),
        .wb_datrd              (wb_datrd),
        .wb_we                 (wb_we),
        .wb_sel                (wb_sel),
        .wb_cyc                (wb_cyc),
        .wb_stb                (wb_stb),
        .wb_ack                (wb_ack),
        .wb_err                (wb_err),
        .bus_r_addr_ready      (bus_r_addr_ready),
        .bus_r_addr_valid      (bus_r_addr_valid),
        .bus_r_addr            (bus_r_addr),
        .bus_r_data_ready      (bus_r_data_ready),
        .bus_r_data_valid      (bus_r_data_valid),
        .bus_r_data            (bus_r_data),
        .bus_r_resp            (bus_r_resp),
        .bus_w_data_addr_ready (bus_w_data_addr_ready),
        .bus_w_data_addr_valid (bus_w_data_addr_valid),
        .bus_w_data            (bus_w_data),
        .bus_w_addr            (bus_w_addr),
        .bus_w_strobe          (bus_w_strobe),
        .bus_w_resp_ready      (bus_w_resp_ready),
        .bus_w_resp_valid      (bus_w_resp_valid),
        .bus_w_resp            (bus_w_resp)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle_no <= cycle_no + 1;

    always @(negedge clock) begin
        if (wb_cyc) begin
            wait_cnt = wait_cnt + 1;
            if (wait_cnt == 1) begin
                seen_adr   = wb_adr;
                seen_datwr = wb_datwr;
                seen_sel   = wb_sel;
                seen_we    = wb_we;
            end
            slave_ack = (slave_mode != 0) && (wait_cnt == slave_cycle);
            slave_err = (slave_mode == 2) && (wait_cnt == slave_cycle);
        end else begin
            wait_cnt  = 0;
            slave_ack = 1'b0;
            slave_err = 1'b0;
        end
    end

    function automatic exp_t make_exp(input logic is_write);
        exp_t e;
        e.is_write = is_write;
        case (slave_mode)
            1: begin e.resp = 2'd1; e.data = is_write ? '0 : slave_rdata; end
            2: begin e.resp = 2'd2; e.data = '0; end
            default: begin e.resp = 2'd3; e.data = '0; end
        endcase
        return e;
    endfunction

    task automatic issue_read(input logic [AW-1:0] addr, output int acc_cycle);
        bit done = 0;
        acc_cycle = -1;
        @(negedge clock);
        bus_r_addr = addr;
        bus_r_addr_valid = 1'b1;
        for (int i = 0; i < 30 && !done; i++) begin
            #1;
            if (bus_r_addr_ready) begin
                done = 1;
                acc_cycle = cycle_no;
                exp_q.push_back(make_exp(1'b0));
            end
            @(negedge clock);
        end
        bus_r_addr_valid = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL read_accept addr=%h: got no ready, required ready within 30 cycles", addr);
        end
    endtask

    task automatic issue_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic [SW-1:0] strobe);
        bit done = 0;
        @(negedge clock);
        bus_w_addr = addr;
        bus_w_data = data;
        bus_w_strobe = strobe;
        bus_w_data_addr_valid = 1'b1;
        for (int i = 0; i < 30 && !done; i++) begin
            #1;
            if (bus_w_data_addr_ready) begin
                done = 1;
                exp_q.push_back(make_exp(1'b1));
            end
            @(negedge clock);
        end
        bus_w_data_addr_valid = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL write_accept addr=%h: got no ready, required ready within 30 cycles", addr);
        end
    endtask

    // Wait for a response, pop the scoreboard, compare, and complete the handshake.
    task automatic collect_resp(input int budget, output int resp_cycle);
        bit got = 0;
        exp_t e;
        resp_cycle = -1;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clock);
            #1;
            if (bus_r_data_valid || bus_w_resp_valid) begin
                got = 1;
                resp_cycle = cycle_no;
                bus_r_data_ready = bus_r_data_valid;
                bus_w_resp_ready = bus_w_resp_valid;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_empty: got a response, required none outstanding");
                end else begin
                    e = exp_q.pop_front();
                    total++;
                    if (bus_w_resp_valid !== e.is_write) begin
                        bad++;
                        $display("FAIL resp_channel: got w_valid=%b, required %b", bus_w_resp_valid, e.is_write);
                    end
                    if (e.is_write) begin
                        if (bus_w_resp !== e.resp) begin
                            bad++;
                            $display("FAIL w_resp: got %0d, required %0d", bus_w_resp, e.resp);
                        end
                    end else begin
                        if (bus_r_resp !== e.resp) begin
                            bad++;
                            $display("FAIL r_resp: got %0d, required %0d", bus_r_resp, e.resp);
                        end
                        total++;
                        if (bus_r_data !== e.data) begin
                            bad++;
                            $display("FAIL r_data: got %h, required %h", bus_r_data, e.data);
                        end
                    end
                end
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL resp_wait: got no response valid, required one within %0d cycles", budget);
        end else begin
            @(negedge clock);
            bus_r_data_ready = 1'b0;
            bus_w_resp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [31:0] got_v[13];
        logic [31:0] want_v[13];
        string nm[13];
        reset = 1'b1;
        bus_r_addr_valid = 1'b0; bus_r_addr = '0;
        bus_w_data_addr_valid = 1'b0; bus_w_addr = '0; bus_w_data = '0; bus_w_strobe = '0;
        bus_r_data_ready = 1'b0; bus_w_resp_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        got_v = '{32'(wb_cyc), 32'(wb_stb), 32'(wb_we), 32'(bus_r_data_valid), 32'(bus_w_resp_valid),
                  wb_adr, wb_datwr, 32'(wb_sel), bus_r_data, 32'(bus_r_resp), 32'(bus_w_resp),
                  32'(bus_r_addr_ready), 32'(bus_w_data_addr_ready)};
        want_v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        nm = '{"cyc", "stb", "we", "r_valid", "w_valid", "adr", "datwr", "sel", "r_data",
               "r_resp", "w_resp", "r_ready", "w_ready"};
        for (int i = 0; i < 13; i++) begin
            total++;
            if (got_v[i] !== want_v[i]) begin
                bad++;
                $display("FAIL reset_%s: got %h, required %h", nm[i], got_v[i], want_v[i]);
            end
        end
    endtask

    task automatic test_arbitration();
        bit want_w[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        bit grant_w;
        bit found;
        int r_left = 2;
        int w_left = 2;
        int rc;
        slave_mode = 1; slave_cycle = 1; slave_rdata = 32'hCAFE_0000;
        @(negedge clock);
        bus_r_addr = 32'h0000_0400; bus_r_addr_valid = 1'b1;
        bus_w_addr = 32'h0000_0500; bus_w_data = 32'hA5A5_0001; bus_w_strobe = 4'hF;
        bus_w_data_addr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            found = 0;
            grant_w = 0;
            for (int i = 0; i < 20 && !found; i++) begin
                #1;
                if (k == 0) begin
                    total++;
                    if (bus_r_addr_ready !== 1'b1 || bus_w_data_addr_ready !== 1'b0) begin
                        bad++;
                        $display("FAIL first_tie_readies: got r=%b w=%b, required r=1 w=0",
                                 bus_r_addr_ready, bus_w_data_addr_ready);
                    end
                end
                if (bus_r_addr_valid && bus_r_addr_ready) begin
                    found = 1; grant_w = 0; r_left--;
                    exp_q.push_back(make_exp(1'b0));
                end else if (bus_w_data_addr_valid && bus_w_data_addr_ready) begin
                    found = 1; grant_w = 1; w_left--;
                    exp_q.push_back(make_exp(1'b1));
                end else begin
                    @(negedge clock);
                end
            end
            total++;
            if (!found || grant_w !== want_w[k]) begin
                bad++;
                $display("FAIL grant_%0d: got found=%0d write=%0d, required write=%0d", k, found, grant_w, want_w[k]);
            end
            @(negedge clock);
            bus_r_addr_valid = (r_left > 0);
            bus_w_data_addr_valid = (w_left > 0);
            bus_r_addr = bus_r_addr + 32'h4;
            bus_w_data = bus_w_data + 32'h1;
            collect_resp(20, rc);
        end
        bus_r_addr_valid = 1'b0;
        bus_w_data_addr_valid = 1'b0;
    endtask

    task automatic test_read();
        int acc;
        int rc;
        slave_mode = 1; slave_cycle = 4; slave_rdata = 32'hDEAD_BEEF;
        issue_read(32'h0000_0100, acc);
        collect_resp(30, rc);
        total++;
        if (rc - acc !== 5) begin
            bad++;
            $display("FAIL read_latency: got %0d cycles, required 5", rc - acc);
        end
        total++;
        if (seen_adr !== 32'h100 || seen_we !== 1'b0 || seen_sel !== 4'hF) begin
            bad++;
            $display("FAIL read_bus: got adr=%h we=%b sel=%b, required adr=100 we=0 sel=1111",
                     seen_adr, seen_we, seen_sel);
        end
    endtask

    task automatic test_write();
        int rc;
        slave_mode = 1; slave_cycle = 1; slave_rdata = 32'h1111_2222;
        issue_write(32'h0000_0020, 32'h1234_5678, 4'b0011);
        collect_resp(30, rc);
        total++;
        if (seen_adr !== 32'h20 || seen_we !== 1'b1 || seen_sel !== 4'b0011 || seen_datwr !== 32'h1234_5678) begin
            bad++;
            $display("FAIL write_bus: got adr=%h we=%b sel=%b dat=%h, required adr=20 we=1 sel=0011 dat=12345678",
                     seen_adr, seen_we, seen_sel, seen_datwr);
        end
    endtask

    task automatic test_error();
        int acc;
        int rc;
        slave_mode = 2; slave_cycle = 2; slave_rdata = 32'h55AA_55AA;
        issue_read(32'h0000_0200, acc);
        collect_resp(30, rc);
        issue_write(32'h0000_0204, 32'h0BAD_0BAD, 4'b1000);
        collect_resp(30, rc);
    endtask

    task automatic test_timeout();
        int acc;
        int rc;
        int cyc_cnt = 0;
        bit dropped = 0;
        slave_mode = 0; slave_rdata = 32'h7777_7777;
        issue_read(32'h0000_0300, acc);
        for (int i = 0; i < 40 && !dropped; i++) begin
            #1;
            if (!wb_cyc) dropped = 1;
            else begin
                cyc_cnt++;
                @(negedge clock);
            end
        end
        total++;
        if (cyc_cnt !== TO) begin
            bad++;
            $display("FAIL timeout_wait: got cyc high %0d cycles, required %0d", cyc_cnt, TO);
        end
        total++;
        if (bus_r_data_valid !== 1'b1 || bus_r_resp !== 2'd3) begin
            bad++;
            $display("FAIL timeout_resp: got valid=%b resp=%0d at cyc drop, required valid=1 resp=3",
                     bus_r_data_valid, bus_r_resp);
        end
        collect_resp(10, rc);
        manual_ack = 1'b1;
        @(negedge clock);
        manual_ack = 1'b0;
        #1;
        total++;
        if (wb_cyc !== 1'b0 || bus_r_data_valid !== 1'b0 || bus_w_resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL late_ack: got cyc=%b r_valid=%b w_valid=%b, required all 0",
                     wb_cyc, bus_r_data_valid, bus_w_resp_valid);
        end
        slave_mode = 1; slave_cycle = 2; slave_rdata = 32'h0BAD_F00D;
        issue_read(32'h0000_0304, acc);
        collect_resp(30, rc);
    endtask

    task automatic test_reset_mid();
        logic [31:0] got_v[13];
        logic [31:0] want_v[13];
        string nm[13];
        slave_mode = 0;
        bus_w_resp_ready = 1'b0;
        issue_write(32'h0000_0040, 32'hFFFF_0000, 4'hF);
        #1;
        total++;
        if (wb_cyc !== 1'b1) begin
            bad++;
            $display("FAIL mid_cyc: got cyc=%b before reset, required 1", wb_cyc);
        end
        reset = 1'b1;
        @(negedge clock);
        #1;
        got_v = '{32'(wb_cyc), 32'(wb_stb), 32'(wb_we), 32'(bus_r_data_valid), 32'(bus_w_resp_valid),
                  wb_adr, wb_datwr, 32'(wb_sel), bus_r_data, 32'(bus_r_resp), 32'(bus_w_resp),
                  32'(bus_r_addr_ready), 32'(bus_w_data_addr_ready)};
        want_v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        nm = '{"cyc", "stb", "we", "r_valid", "w_valid", "adr", "datwr", "sel", "r_data",
               "r_resp", "w_resp", "r_ready", "w_ready"};
        for (int i = 0; i < 13; i++) begin
            total++;
            if (got_v[i] !== want_v[i]) begin
                bad++;
                $display("FAIL midreset_%s: got %h, required %h", nm[i], got_v[i], want_v[i]);
            end
        end
        exp_q.delete();
        reset = 1'b0;
        @(negedge clock);
        bus_r_addr_valid = 1'b1;
        bus_w_data_addr_valid = 1'b1;
        #1;
        total++;
        if (bus_r_addr_ready !== 1'b1 || bus_w_data_addr_ready !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_tie: got r=%b w=%b, required r=1 w=0",
                     bus_r_addr_ready, bus_w_data_addr_ready);
        end
        bus_r_addr_valid = 1'b0;
        bus_w_data_addr_valid = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_read();
        test_write();
        test_error();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
